// File: rtl/switch_egress_pkg.sv
// ----------------------------------------------------------------------------
// switch_egress_pkg
// Shared types and widths for the switch egress stage: the packet word that
// travels through the per-port FIFOs and the source tag of the merged stream.
// Build option: SWITCH_EGRESS_STATS_EN adds saturating per-port drop counters.
// ----------------------------------------------------------------------------
package switch_egress_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Round-robin step: the pointer alternates between the two ports.
  function automatic src_e other_src(input src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/switch_egress_fifo.sv
// ----------------------------------------------------------------------------
// switch_egress_fifo
// Small synchronous FIFO holding one port's routed words.
//   i_clk       clock
//   i_rst       synchronous active-high reset (empties the FIFO)
//   i_push      write request; ignored while full (the word is lost upstream)
//   i_push_data word to write
//   i_pop       read request; ignored while empty
//   o_pop_data  head-of-queue word, valid whenever o_empty is low
//   o_empty     no words stored
//   o_count     occupancy, 0..DEPTH
// A pop in the same cycle as a push at full does not make room: the full
// decision uses the count registered at the edge.
// Build option: none (SWITCH_EGRESS_STATS_EN is handled in the top level).
// ----------------------------------------------------------------------------
module switch_egress_fifo
  import switch_egress_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  pkt_t                   i_push_data,
  input  logic                   i_pop,
  output pkt_t                   o_pop_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  pkt_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full     = (r_count == CNT_FULL);
  assign o_empty    = (r_count == '0);
  assign w_do_push  = i_push && !w_full;
  assign w_do_pop   = i_pop && !o_empty;
  // Head word is read combinationally so a word pushed in cycle N can be
  // moved to the output register at the end of cycle N+1.
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/switch_egress_arb.sv
// ----------------------------------------------------------------------------
// switch_egress_arb
// Egress stage behind the address-routing switch. Each routed port (A, B) is
// buffered in its own FIFO; a round-robin arbiter merges them into a single
// valid/ready stream tagged with the source port. Words arriving at a full
// FIFO are dropped and reported with a one-cycle pulse.
//   clock                 single clock
//   rst                   synchronous active-high reset
//   vld_a/addr_a/data_a   port A word (no ready, cannot be stalled)
//   vld_b/addr_b/data_b   port B word
//   out_vld/out_rdy       output handshake
//   out_addr/out_data     output word
//   out_src               source of the output word: 0 = A, 1 = B
//   drop_a/drop_b         registered pulse, one cycle after an overflowing word
//   drop_cnt_a/drop_cnt_b saturating drop counters
//                         (only when SWITCH_EGRESS_STATS_EN is defined)
// ----------------------------------------------------------------------------
module switch_egress_arb
  import switch_egress_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              vld_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              vld_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              drop_a,
`ifdef SWITCH_EGRESS_STATS_EN
  output logic              drop_b,
  output logic [CNT_W-1:0]  drop_cnt_a,
  output logic [CNT_W-1:0]  drop_cnt_b
`else
  output logic              drop_b
`endif
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  // Per-port views, index 0 = A, 1 = B (matches src_e encoding).
  logic [1:0]     w_in_vld;
  pkt_t           w_in_pkt [2];
  pkt_t           w_head   [2];
  logic [1:0]     w_empty;
  logic [PTR_W:0] w_count  [2];
  logic [1:0]     w_pop;
  logic [1:0]     w_drop_next;

  logic           w_free;
  logic           w_grant_vld;
  src_e           w_grant_src;
  pkt_t           w_grant_pkt;

  logic           r_out_vld;
  pkt_t           r_out_pkt;
  src_e           r_out_src;
  src_e           r_rr_ptr;

  assign w_in_vld    = {vld_b, vld_a};
  assign w_in_pkt[0] = '{addr: addr_a, data: data_a};
  assign w_in_pkt[1] = '{addr: addr_b, data: data_b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      switch_egress_fifo #(
        .DEPTH (DEPTH)
      ) u_fifo (
        .i_clk       (clock),
        .i_rst       (rst),
        .i_push      (w_in_vld[gi]),
        .i_push_data (w_in_pkt[gi]),
        .i_pop       (w_pop[gi]),
        .o_pop_data  (w_head[gi]),
        .o_empty     (w_empty[gi]),
        .o_count     (w_count[gi])
      );

      // Overflow judged on the count registered at this edge, so a pop in
      // the same cycle never rescues the incoming word.
      assign w_drop_next[gi] = w_in_vld[gi] && (w_count[gi] == CNT_FULL);

      logic r_drop;
      always_ff @(posedge clock) begin
        if (rst) begin
          r_drop <= 1'b0;
        end else begin
          r_drop <= w_drop_next[gi];
        end
      end

`ifdef SWITCH_EGRESS_STATS_EN
      logic [CNT_W-1:0] r_drop_cnt;
      always_ff @(posedge clock) begin
        if (rst) begin
          r_drop_cnt <= '0;
        end else if (w_drop_next[gi] && (r_drop_cnt != '1)) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
`endif
    end
  endgenerate

  // Arbitration: the output register accepts a new word when it is empty or
  // being consumed this cycle. The round-robin pointer only matters when both
  // FIFOs have data; otherwise the single non-empty port wins.
  always_comb begin
    w_free      = !r_out_vld || out_rdy;
    w_grant_vld = w_free && (w_empty != 2'b11);
    w_grant_src = SRC_A;
    if (!w_empty[0] && !w_empty[1]) begin
      w_grant_src = r_rr_ptr;
    end else if (!w_empty[1]) begin
      w_grant_src = SRC_B;
    end
    w_pop[0]    = w_grant_vld && (w_grant_src == SRC_A);
    w_pop[1]    = w_grant_vld && (w_grant_src == SRC_B);
    w_grant_pkt = (w_grant_src == SRC_B) ? w_head[1] : w_head[0];
  end

  // Output register. While stalled (valid and not ready) nothing changes.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_pkt <= '0;
      r_out_src <= SRC_A;
      r_rr_ptr  <= SRC_A;
    end else if (w_free) begin
      r_out_vld <= w_grant_vld;
      if (w_grant_vld) begin
        r_out_pkt <= w_grant_pkt;
        r_out_src <= w_grant_src;
        r_rr_ptr  <= other_src(r_rr_ptr);
      end
    end
  end

  assign out_vld  = r_out_vld;
  assign out_addr = r_out_pkt.addr;
  assign out_data = r_out_pkt.data;
  assign out_src  = (r_out_src == SRC_B);
  assign drop_a   = g_port[0].r_drop;
  assign drop_b   = g_port[1].r_drop;

`ifdef SWITCH_EGRESS_STATS_EN
  assign drop_cnt_a = g_port[0].r_drop_cnt;
  assign drop_cnt_b = g_port[1].r_drop_cnt;
`endif

endmodule

// File: tb/tb_switch_egress_arb.sv
// ----------------------------------------------------------------------------
// tb_switch_egress_arb
// Self-checking bench for switch_egress_arb (DEPTH = 4). Directed scenarios
// cover reset, single-word latency, contention ordering, overflow, mid-run
// reset and (with SWITCH_EGRESS_STATS_EN) counter saturation. Randomized
// traffic is checked against a queue-based reference model of the egress
// rules. Inputs change on the falling edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_switch_egress_arb;
  import switch_egress_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        rst;
  logic        vld_a, vld_b, out_rdy;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic        out_vld, out_src, drop_a, drop_b;
  logic [7:0]  out_addr;
  logic [15:0] out_data;
`ifdef SWITCH_EGRESS_STATS_EN
  logic [15:0] drop_cnt_a, drop_cnt_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  switch_egress_arb #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .rst      (rst),
    .vld_a    (vld_a),
    .addr_a   (addr_a),
    .data_a   (data_a),
    .vld_b    (vld_b),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_src  (out_src),
    .drop_a   (drop_a),
`ifdef SWITCH_EGRESS_STATS_EN
    .drop_b     (drop_b),
    .drop_cnt_a (drop_cnt_a),
    .drop_cnt_b (drop_cnt_b)
`else
    .drop_b   (drop_b)
`endif
  );

  task automatic drive(input logic va, input logic [7:0] aa, input logic [15:0] da,
                       input logic vb, input logic [7:0] ab, input logic [15:0] db,
                       input logic rdy);
    vld_a = va; addr_a = aa; data_a = da;
    vld_b = vb; addr_b = ab; data_b = db;
    out_rdy = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One reset cycle; returns at the falling edge that starts cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'h33, 16'h3333, 1'b1, 8'h44, 16'h4444, 1'b1);
    tick();
    n_checks++; if (out_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", out_vld); else n_pass++;
    n_checks++; if (out_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", out_addr); else n_pass++;
    n_checks++; if (out_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", out_data); else n_pass++;
    n_checks++; if (out_src !== 1'b0) $display("FAIL reset_src: got %b want 0", out_src); else n_pass++;
    n_checks++; if ({drop_a, drop_b} !== 2'b00) $display("FAIL reset_drop: got %b want 00", {drop_a, drop_b}); else n_pass++;
    rst = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (out_vld !== 1'b0) $display("FAIL reset_nocapture cyc %0d: got vld %b want 0", c, out_vld); else n_pass++;
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 8'h10, 16'hBEEF, 1'b0, 8'h00, 16'h0000, 1'b1);
    tick();
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
    n_checks++; if (out_vld !== 1'b0) $display("FAIL single_c1_vld: got %b want 0", out_vld); else n_pass++;
    tick();
    $display("single: cycle 2 vld=%b addr=%h data=%h src=%b", out_vld, out_addr, out_data, out_src);
    n_checks++; if (out_vld !== 1'b1) $display("FAIL single_c2_vld: got %b want 1", out_vld); else n_pass++;
    n_checks++; if (out_addr !== 8'h10) $display("FAIL single_addr: got %h want 10", out_addr); else n_pass++;
    n_checks++; if (out_data !== 16'hBEEF) $display("FAIL single_data: got %h want beef", out_data); else n_pass++;
    n_checks++; if (out_src !== 1'b0) $display("FAIL single_src: got %b want 0", out_src); else n_pass++;
    tick();
    n_checks++; if (out_vld !== 1'b0) $display("FAIL single_c3_vld: got %b want 0", out_vld); else n_pass++;
  endtask

  task automatic test_contention();
    logic [7:0]  ea;
    logic [15:0] ed;
    logic        es, ev;
    int          k;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c < 4)
        drive(1'b1, 8'(8'hA0 + c), 16'(16'hDA00 + c), 1'b1, 8'(8'hB0 + c), 16'(16'hDB00 + c), 1'b1);
      else
        drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
      ev = (c >= 2) && (c <= 9);
      n_checks++; if (out_vld !== ev) $display("FAIL contention_vld cyc %0d: got %b want %b", c, out_vld, ev); else n_pass++;
      if (ev) begin
        k  = c - 2;
        es = k[0];
        ea = es ? 8'(8'hB0 + k / 2) : 8'(8'hA0 + k / 2);
        ed = es ? 16'(16'hDB00 + k / 2) : 16'(16'hDA00 + k / 2);
        $display("contention: cycle %0d addr=%h data=%h src=%b", c, out_addr, out_data, out_src);
        n_checks++; if ({out_addr, out_data, out_src} !== {ea, ed, es})
          $display("FAIL contention_word cyc %0d: got %h/%h/%b want %h/%h/%b", c, out_addr, out_data, out_src, ea, ed, es);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ea;
    logic       ev, ed;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c < 6)
        drive(1'b1, 8'(8'h40 + c), 16'(16'h1000 + c), 1'b0, 8'h00, 16'h0000, 1'b0);
      else
        drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, c >= 8);
      ed = (c == 6);
      n_checks++; if (drop_a !== ed) $display("FAIL overflow_drop_a cyc %0d: got %b want %b", c, drop_a, ed); else n_pass++;
      n_checks++; if (drop_b !== 1'b0) $display("FAIL overflow_drop_b cyc %0d: got %b want 0", c, drop_b); else n_pass++;
      ev = (c >= 2) && (c <= 12);
      n_checks++; if (out_vld !== ev) $display("FAIL overflow_vld cyc %0d: got %b want %b", c, out_vld, ev); else n_pass++;
      if (ev) begin
        ea = (c <= 8) ? 8'h40 : 8'(8'h40 + c - 8);
        n_checks++; if ({out_addr, out_data, out_src} !== {ea, 16'(16'h1000 + ea - 8'h40), 1'b0})
          $display("FAIL overflow_word cyc %0d: got %h/%h/%b want %h", c, out_addr, out_data, out_src, ea);
        else n_pass++;
      end
      tick();
    end
  endtask

  // Random traffic against a queue model of the egress rules.
  task automatic test_random(input bit toggle_rdy, input int n_cycles);
    pkt_t qa[$];
    pkt_t qb[$];
    pkt_t m_pkt, pa, pb;
    bit   ptr_b, m_vld, m_src, m_da, m_db;
    bit   va, vb, rdy, na, nb, g;
    do_reset();
    ptr_b = 1'b0; m_vld = 1'b0; m_src = 1'b0; m_da = 1'b0; m_db = 1'b0;
    m_pkt = '0;
    for (int c = 0; c < n_cycles; c++) begin
      n_checks++; if (out_vld !== m_vld) $display("FAIL rand%0d_vld cyc %0d: got %b want %b", toggle_rdy, c, out_vld, m_vld); else n_pass++;
      if (m_vld) begin
        n_checks++; if ({out_addr, out_data, out_src} !== {m_pkt.addr, m_pkt.data, m_src})
          $display("FAIL rand%0d_word cyc %0d: got %h/%h/%b want %h/%h/%b", toggle_rdy, c,
                   out_addr, out_data, out_src, m_pkt.addr, m_pkt.data, m_src);
        else n_pass++;
      end
      n_checks++; if ({drop_a, drop_b} !== {m_da, m_db})
        $display("FAIL rand%0d_drop cyc %0d: got %b%b want %b%b", toggle_rdy, c, drop_a, drop_b, m_da, m_db);
      else n_pass++;

      va  = ($urandom_range(0, 99) < 60);
      vb  = ($urandom_range(0, 99) < 60);
      rdy = toggle_rdy ? c[0] : ($urandom_range(0, 1) == 1);
      pa  = '{addr: 8'($urandom), data: 16'($urandom)};
      pb  = '{addr: 8'($urandom), data: 16'($urandom)};
      drive(va, pa.addr, pa.data, vb, pb.addr, pb.data, rdy);

      // Expected state after the coming edge.
      na   = (qa.size() != 0);
      nb   = (qb.size() != 0);
      m_da = va && (qa.size() == DEPTH);
      m_db = vb && (qb.size() == DEPTH);
      if (!m_vld || rdy) begin
        if (na || nb) begin
          g = (na && nb) ? ptr_b : nb;
          if (g) m_pkt = qb.pop_front();
          else   m_pkt = qa.pop_front();
          m_src = g;
          m_vld = 1'b1;
          ptr_b = !ptr_b;
        end else begin
          m_vld = 1'b0;
        end
      end
      if (va && !m_da) qa.push_back(pa);
      if (vb && !m_db) qb.push_back(pb);
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic ev;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 8'(8'hC0 + c), 16'(16'hC000 + c), c < 3, 8'(8'hD0 + c), 16'(16'hD000 + c), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
    n_checks++; if ({out_vld, out_addr} !== {1'b1, 8'hC0}) $display("FAIL midrst_setup: got %b/%h want 1/c0", out_vld, out_addr); else n_pass++;
    rst = 1'b1;
    drive(1'b1, 8'hEE, 16'hEEEE, 1'b1, 8'hEF, 16'hEFEF, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
    n_checks++; if ({out_vld, out_addr, out_data, out_src} !== {1'b0, 8'h00, 16'h0000, 1'b0})
      $display("FAIL midrst_clear: got %b/%h/%h/%b want 0/00/0000/0", out_vld, out_addr, out_data, out_src);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++; if (out_vld !== 1'b0) $display("FAIL midrst_stale cyc %0d: got vld %b addr %h want vld 0", c, out_vld, out_addr); else n_pass++;
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b1, 8'h77, 16'h7777, 1'b1);
    for (int c = 0; c < 4; c++) begin
      ev = (c == 2);
      n_checks++; if (out_vld !== ev) $display("FAIL midrst_b_vld cyc %0d: got %b want %b", c, out_vld, ev); else n_pass++;
      if (ev) begin
        $display("midrst: B word addr=%h data=%h src=%b", out_addr, out_data, out_src);
        n_checks++; if ({out_addr, out_data, out_src} !== {8'h77, 16'h7777, 1'b1})
          $display("FAIL midrst_b_word: got %h/%h/%b want 77/7777/1", out_addr, out_data, out_src);
        else n_pass++;
      end
      tick();
      drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
    end
  endtask

`ifdef SWITCH_EGRESS_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int c = 0; c < 70010; c++) begin
      drive(1'b0, 8'h00, 16'h0000, 1'b1, 8'(c), 16'(c), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
    tick();
    n_checks++; if (drop_cnt_b !== 16'hFFFF) $display("FAIL stats_cnt_b: got %h want ffff", drop_cnt_b); else n_pass++;
    n_checks++; if (drop_cnt_a !== 16'h0000) $display("FAIL stats_cnt_a: got %h want 0000", drop_cnt_a); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({drop_cnt_a, drop_cnt_b} !== 32'h0) $display("FAIL stats_reset: got %h/%h want 0/0", drop_cnt_a, drop_cnt_b); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
    @(negedge clock);
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_random(1'b1, 300);
    test_random(1'b0, 400);
    test_mid_reset();
`ifdef SWITCH_EGRESS_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
